md_unit_ctrl: RTL and testbench

Multiply/divide sequencer with the HI/LO register pair, placed in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo operations from E.
- Models the multi-cycle latency with a down-counter and commits results to HI/LO on completion.
- Drives md_stall to the stall unit so that D-stage mf/mt/md instructions are held while an operation is in flight.
- Serves mfhi/mflo reads combinationally.

---
 rtl/md_unit_ctrl.sv | 164 ++++++++++++++++
 tb/tb_md_unit_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer and HI/LO register pair for the E stage.
//
// Accepts mult/multu/div/divu/mthi/mtlo from E. A mult/div computes its 64-bit
// result into pending registers on the issue edge. A down-counter then models the
// unit latency. The pending result is committed to HI/LO on the edge where the
// counter reaches zero. mfhi/mflo reads are served combinationally from HI/LO.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset, clears all state
//   md_op     in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   md_a      in   [31:0] rs operand
//   md_b      in   [31:0] rt operand
//   mf_sel    in   0 selects HI, 1 selects LO on mf_data
//   busy      out  operation in flight (registered)
//   start     out  mult/div accepted this cycle (combinational)
//   md_stall  out  start | busy
//   hi, lo    out  [31:0] HI/LO registers
//   mf_data   out  [31:0] mf_sel ? lo : hi
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        mf_sel,
  output logic        busy,
  output logic        start,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]     r_hi, w_hi_nxt;
  logic [31:0]     r_lo, w_lo_nxt;
  logic [31:0]     r_pend_hi, w_pend_hi_nxt;
  logic [31:0]     r_pend_lo, w_pend_lo_nxt;
  // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
  logic            r_pend_ok, w_pend_ok_nxt;

  // Operation decode.
  logic w_is_mult, w_is_div, w_start;
  assign w_is_mult = (md_op == OpMult) || (md_op == OpMultu);
  assign w_is_div  = (md_op == OpDiv)  || (md_op == OpDivu);
  assign w_start   = (r_state == StIdle) && (w_is_mult || w_is_div);

  // Products: low 64 bits of the extended operands give the signed/unsigned result.
  logic [63:0] w_prod_s, w_prod_u;
  assign w_prod_s = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
  assign w_prod_u = {32'd0, md_a} * {32'd0, md_b};

  // Division on magnitudes, signs restored afterwards. A zero divisor is replaced by
  // one so no X is ever produced; the result is discarded via r_pend_ok.
  logic        w_b_zero, w_a_neg, w_b_neg;
  logic [31:0] w_div_b, w_mag_a, w_mag_b, w_q, w_r, w_q_res, w_r_res;
  assign w_b_zero = (md_b == 32'd0);
  assign w_div_b  = w_b_zero ? 32'd1 : md_b;
  assign w_a_neg  = (md_op == OpDiv) && md_a[31];
  assign w_b_neg  = (md_op == OpDiv) && w_div_b[31];
  assign w_mag_a  = w_a_neg ? (32'd0 - md_a) : md_a;
  assign w_mag_b  = w_b_neg ? (32'd0 - w_div_b) : w_div_b;
  assign w_q      = w_mag_a / w_mag_b;
  assign w_r      = w_mag_a % w_mag_b;
  assign w_q_res  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
  assign w_r_res  = w_a_neg ? (32'd0 - w_r) : w_r;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_ok_nxt = r_pend_ok;
    unique case (r_state)
      StIdle: begin
        if (w_is_mult) begin
          w_state_nxt   = StRun;
          w_cnt_nxt     = MultCnt;
          w_pend_ok_nxt = 1'b1;
          if (md_op == OpMult) begin
            w_pend_hi_nxt = w_prod_s[63:32];
            w_pend_lo_nxt = w_prod_s[31:0];
          end else begin
            w_pend_hi_nxt = w_prod_u[63:32];
            w_pend_lo_nxt = w_prod_u[31:0];
          end
        end else if (w_is_div) begin
          w_state_nxt   = StRun;
          w_cnt_nxt     = DivCnt;
          w_pend_ok_nxt = !w_b_zero;
          w_pend_hi_nxt = w_r_res;
          w_pend_lo_nxt = w_q_res;
        end else if (md_op == OpMthi) begin
          w_hi_nxt = md_a;
        end else if (md_op == OpMtlo) begin
          w_lo_nxt = md_a;
        end
      end
      StRun: begin
        // Any md_op is ignored while running.
        w_cnt_nxt = r_cnt - CntOne;
        if (r_cnt == CntOne) begin
          w_state_nxt = StIdle;
          if (r_pend_ok) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_ok <= w_pend_ok_nxt;
    end
  end

  assign busy     = (r_state == StRun);
  assign start    = w_start;
  assign md_stall = w_start | busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign mf_data  = mf_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases followed by random operations
// compared against an arithmetic reference model of HI/LO.
module tb_md_unit_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_a = 32'd0;
  logic [31:0] md_b = 32'd0;
  logic        mf_sel = 1'b0;
  logic        busy, start, md_stall;
  logic [31:0] hi, lo, mf_data;

  int n_pass  = 0;
  int n_total = 0;

  // Reference HI/LO.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit_ctrl #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .md_a    (md_a),
    .md_b    (md_b),
    .mf_sel  (mf_sel),
    .busy    (busy),
    .start   (start),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Check HI/LO and mf_data against the model with a random mf_sel.
  task automatic check_regs(input string tag);
    mf_sel = 1'($urandom_range(0, 1));
    #1;
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    check({tag, "_mf"}, mf_data, mf_sel ? m_lo : m_hi);
  endtask

  // Architectural result of a mult/div op; ok=0 means HI/LO must stay unchanged.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic ok, output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    eh = 32'd0;
    el = 32'd0;
    case (op)
      3'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      3'd2: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
      3'd3: begin
        if (b == 32'd0) ok = 1'b0;
        else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      end
      3'd4: begin
        if (b == 32'd0) ok = 1'b0;
        else begin up = ua / ub; eh = up[31:0]; up = ua % ub; el = eh; eh = up[31:0]; end
      end
      default: ok = 1'b0;
    endcase
    // divu: lo is the quotient, hi the remainder
    if (op == 3'd4 && ok) begin
      up = ua / ub;
      el = up[31:0];
      up = ua % ub;
      eh = up[31:0];
    end
  endtask

  // Issue a mult/div at the current cycle (just after an edge) and follow it to commit.
  // ign_rand=1 drives random ops during busy, otherwise ign_op/ign_a.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ign_rand, input logic [2:0] ign_op,
                        input logic [31:0] ign_a);
    logic        ok;
    logic [31:0] eh, el;
    int unsigned n;
    model(op, a, b, ok, eh, el);
    n = (op == 3'd1 || op == 3'd2) ? MultN : DivN;
    md_op = op;
    md_a  = a;
    md_b  = b;
    #1;
    check_bit({tag, "_start"}, start, 1'b1);
    check_bit({tag, "_stall_issue"}, md_stall, 1'b1);
    check_bit({tag, "_busy_issue"}, busy, 1'b0);
    tick();
    for (int i = 1; i <= int'(n); i++) begin
      md_op = ign_rand ? 3'($urandom_range(0, 7)) : ign_op;
      md_a  = ign_rand ? $urandom : ign_a;
      md_b  = $urandom;
      #1;
      check_bit({tag, "_busy_run"}, busy, 1'b1);
      check_bit({tag, "_start_run"}, start, 1'b0);
      check_bit({tag, "_stall_run"}, md_stall, 1'b1);
      check_regs({tag, "_run"});
      tick();
    end
    md_op = 3'd0;
    if (ok) begin
      m_hi = eh;
      m_lo = el;
    end
    #1;
    check_bit({tag, "_busy_done"}, busy, 1'b0);
    check_bit({tag, "_stall_done"}, md_stall, 1'b0);
    check_regs({tag, "_done"});
  endtask

  // mthi/mtlo in idle.
  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    md_op = op;
    md_a  = a;
    md_b  = $urandom;
    #1;
    check_bit({tag, "_start"}, start, 1'b0);
    check_bit({tag, "_stall"}, md_stall, 1'b0);
    tick();
    md_op = 3'd0;
    if (op == 3'd5) m_hi = a;
    else m_lo = a;
    #1;
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_regs(tag);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_start", start, 1'b0);
    check_bit("rst_stall", md_stall, 1'b0);
    check_regs("rst");

    // Directed cases
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 3'd0, 32'd0);
    check("mult_neg_hi_k", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_k", lo, 32'hFFFF_FFF1);
    tick();
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0, 32'd0);
    check("multu_hi_k", hi, 32'h0000_0001);
    check("multu_lo_k", lo, 32'hFFFF_FFFE);
    tick();
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0, 32'd0);
    check("div_neg_lo_k", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_k", hi, 32'hFFFF_FFFF);
    // Back-to-back: issue in the first cycle after busy falls.
    run_op("divu", 3'd4, 32'd7, 32'd2, 1'b0, 3'd0, 32'd0);
    check("divu_lo_k", lo, 32'd3);
    check("divu_hi_k", hi, 32'd1);
    tick();
    run_mt("mthi", 3'd5, 32'h1234_5678);
    mf_sel = 1'b0;
    #1;
    check("mthi_mf_k", mf_data, 32'h1234_5678);
    tick();
    run_op("mult_mtlo_ign", 3'd1, 32'd7, 32'd9, 1'b0, 3'd6, 32'h0000_AAAA);
    check("mult_mtlo_lo_k", lo, 32'd63);
    tick();
    run_op("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0, 32'd0);

    // Reset in the third cycle of a div
    run_mt("set_hi", 3'd5, 32'h11);
    run_mt("set_lo", 3'd6, 32'h22);
    md_op = 3'd3;
    md_a  = 32'd1000;
    md_b  = 32'd7;
    tick();
    md_op = 3'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    check_bit("rstmid_busy", busy, 1'b0);
    check_bit("rstmid_stall", md_stall, 1'b0);
    check_regs("rstmid");
    for (int i = 0; i < int'(DivN) + 2; i++) tick();
    check_bit("rstmid_late_busy", busy, 1'b0);
    check_regs("rstmid_late");
    run_op("multu_after_rst", 3'd2, 32'd3, 32'd4, 1'b0, 3'd0, 32'd0);
    check("multu_after_rst_lo_k", lo, 32'd12);
    tick();

    // Divide by zero leaves HI/LO unchanged
    run_mt("dz_hi", 3'd5, 32'h5);
    run_mt("dz_lo", 3'd6, 32'h6);
    run_op("div_zero", 3'd3, 32'd100, 32'd0, 1'b0, 3'd0, 32'd0);
    check("div_zero_hi_k", hi, 32'h5);
    check("div_zero_lo_k", lo, 32'h6);
    run_op("divu_zero", 3'd4, 32'd100, 32'd0, 1'b1, 3'd0, 32'd0);

    // Random operations
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (rop >= 3'd1 && rop <= 3'd4) begin
        run_op("rnd_md", rop, ra, rb, 1'b1, 3'd0, 32'd0);
      end else if (rop == 3'd5 || rop == 3'd6) begin
        run_mt("rnd_mt", rop, ra);
      end else begin
        md_op = rop;
        md_a  = ra;
        md_b  = rb;
        #1;
        check_bit("rnd_none_start", start, 1'b0);
        tick();
        md_op = 3'd0;
        #1;
        check_bit("rnd_none_busy", busy, 1'b0);
        check_regs("rnd_none");
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
